// File: rtl/uart_matrix_result_tx.sv
// Frames an NxN matrix of 16-bit results into bytes for the UART tx:
// A5, N, elements MSB-first row-major, XOR checksum of all but the header.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, size     frame request and N, sampled only in IDLE
//   rd_addr/rd_data result element read, data valid 1 clk after the address
//   tx_byte/tx_start byte request to the transmitter, held until done edge
//   tx_busy/tx_done transmitter status / done level (rising edge counts)
//   busy/done/err   frame in progress / end pulse / bad-size pulse
module uart_matrix_result_tx #(
  parameter int         MAX_SIZE   = 10,
  parameter int         ADDR_W     = 7,
  parameter int         GAP_CYCLES = 12500,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        size,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic [7:0]        tx_byte,
  output logic              tx_start,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int GW =
    (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [7:0] MAX_N = 8'(MAX_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_FETCH
  } state_t;

  // Which byte is in flight, so GAP knows what comes next.
  typedef enum logic [2:0] {
    P_HDR,
    P_N,
    P_HI,
    P_LO,
    P_CK
  } phase_t;

  state_t        state_q;
  state_t        state_d;
  phase_t        phase_q;
  logic [7:0]    n_q;
  logic [7:0]    total_q;
  logic [7:0]    e_q;
  logic [7:0]    csum_q;
  logic [7:0]    hold_lo_q;
  logic [GW-1:0] gap_q;
  logic          tx_done_q;

  logic        done_edge;
  logic        gap_zero;
  logic        size_ok;
  logic        accept;
  logic        more;
  logic [15:0] sq;
  logic        unused_tx_busy;

  assign unused_tx_busy = tx_busy;
  assign done_edge = tx_done & ~tx_done_q;
  assign gap_zero  = (gap_q == '0);
  assign size_ok   = (size != 8'd0) && (size <= MAX_N);
  // done wins over a same-cycle start
  assign accept    = (state_q == S_IDLE) && start && !done;
  assign more      = (e_q < total_q);
  assign sq        = 16'(size) * 16'(size);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept && size_ok) state_d = S_SEND;
      S_SEND:
        if (done_edge) state_d = S_GAP;
      S_GAP:
        if (gap_zero) begin
          unique case (phase_q)
            P_HDR:   state_d = S_SEND;
            P_N:     state_d = S_FETCH;
            P_HI:    state_d = S_SEND;
            P_LO:    state_d = more ? S_FETCH : S_SEND;
            default: state_d = S_IDLE;
          endcase
        end
      S_FETCH: state_d = S_SEND;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_start = (state_q == S_SEND);
    busy     = (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= P_HDR;
      n_q       <= '0;
      total_q   <= '0;
      e_q       <= '0;
      csum_q    <= '0;
      hold_lo_q <= '0;
      gap_q     <= '0;
      tx_done_q <= 1'b0;
      rd_addr   <= '0;
      tx_byte   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      tx_done_q <= tx_done;
      done      <= 1'b0;
      err       <= 1'b0;
      unique case (state_q)
        S_IDLE:
          if (accept) begin
            if (size_ok) begin
              n_q     <= size;
              total_q <= sq[7:0];
              e_q     <= '0;
              csum_q  <= '0;
              phase_q <= P_HDR;
              tx_byte <= HEADER;
            end else begin
              err <= 1'b1;
            end
          end
        S_SEND:
          if (done_edge) begin
            if (phase_q != P_HDR && phase_q != P_CK)
              csum_q <= csum_q ^ tx_byte;
            gap_q <= GAP_LOAD;
          end
        S_GAP:
          if (!gap_zero) begin
            gap_q <= gap_q - GW'(1);
          end else begin
            unique case (phase_q)
              P_HDR: begin
                tx_byte <= n_q;
                phase_q <= P_N;
              end
              P_N: rd_addr <= ADDR_W'(e_q);
              P_HI: begin
                tx_byte <= hold_lo_q;
                phase_q <= P_LO;
              end
              P_LO:
                if (more) begin
                  rd_addr <= ADDR_W'(e_q);
                end else begin
                  tx_byte <= csum_q;
                  phase_q <= P_CK;
                end
              default: done <= 1'b1;
            endcase
          end
        S_FETCH: begin
          hold_lo_q <= rd_data[7:0];
          tx_byte   <= rd_data[15:8];
          e_q       <= e_q + 8'd1;
          phase_q   <= P_HI;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_matrix_result_tx.sv
// Bench for uart_matrix_result_tx: vector table of frames plus
// reset-abort and held-done / mid-frame-start sequences.
module tb_uart_matrix_result_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  size;
  logic [6:0]  rd_addr;
  logic [15:0] rd_data;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_busy;
  logic        tx_done;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  uart_matrix_result_tx #(
    .MAX_SIZE(10),
    .ADDR_W(7),
    .GAP_CYCLES(4),
    .HEADER(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .size(size),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .tx_byte(tx_byte),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .busy(busy),
    .done(done),
    .err(err)
  );

  logic [15:0] mem [128];
  assign rd_data = mem[rd_addr];

  // transmitter model: take byte, 3 clk latency, done high 3 clk
  logic       model_en;
  logic       td_man;
  logic       m_done = 1'b0;
  int         m_ph = 0;
  int         m_cnt = 0;
  int         n_edges = 0;
  logic [7:0] cap_b [$];
  int         cap_a [$];

  assign tx_done = model_en ? m_done : td_man;
  assign tx_busy = model_en ? (m_ph != 0) : 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph   <= 0;
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else begin
      case (m_ph)
        0: if (model_en && tx_start) begin
          cap_b.push_back(tx_byte);
          cap_a.push_back(int'(rd_addr));
          m_ph  <= 1;
          m_cnt <= 2;
        end
        1: if (m_cnt == 0) begin
          m_done  <= 1'b1;
          m_ph    <= 2;
          m_cnt   <= 2;
          n_edges <= n_edges + 1;
        end else m_cnt <= m_cnt - 1;
        default: if (m_cnt == 0) begin
          m_done <= 1'b0;
          m_ph   <= 0;
        end else m_cnt <= m_cnt - 1;
      endcase
    end
  end

  int         stable_bad = 0;
  logic       ts_q = 1'b0;
  logic [7:0] tb_q = 8'h00;
  always @(posedge clk) begin
    if (tx_start && ts_q && tx_byte != tb_q)
      stable_bad <= stable_bad + 1;
    ts_q <= tx_start;
    tb_q <= tx_byte;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act,
                     input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  name, act, exp);
  endtask

  typedef struct {
    logic [7:0] size;
    int         pat;
    bit         exp_err;
    int         exp_len;
    logic [7:0] exp_ck;
  } vec_t;

  vec_t vecs [7];

  task automatic load_mem(input int pat);
    for (int i = 0; i < 128; i++) begin
      case (pat)
        0: mem[i] = (i == 0) ? 16'h1234 : 16'h0000;
        1: case (i)
          0: mem[i] = 16'h0001;
          1: mem[i] = 16'h0203;
          2: mem[i] = 16'hFFFF;
          3: mem[i] = 16'h8000;
          default: mem[i] = 16'h0000;
        endcase
        default: mem[i] = 16'(i * 257);
      endcase
    end
  endtask

  function automatic logic [7:0] exp_byte(
    input int f, input logic [7:0] n,
    input int len, input logic [7:0] ck);
    int k;
    k = (f - 2) / 2;
    if (f == 0) return 8'hA5;
    if (f == 1) return n;
    if (f == len - 1) return ck;
    return (f % 2 == 0) ? mem[k][15:8] : mem[k][7:0];
  endfunction

  task automatic wait_frame(input int base, input int first,
                            input logic [7:0] n,
                            input int exp_len,
                            input logic [7:0] exp_ck);
    int dn = 0;
    int busy_bad = 0;
    int bad_b = 0;
    int bad_a = 0;
    int got = 0;
    int s0 = stable_bad;
    int cnt;
    int i;
    for (int c = 0; c < 6000 && got == 0; c++) begin
      @(posedge clk); #1;
      if (done) begin
        got = 1;
        dn++;
        chk("busy_at_done", int'(busy), 0);
      end else if (!busy) busy_bad++;
    end
    chk("frame_done_seen", got, 1);
    repeat (30) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    cnt = cap_b.size() - base;
    chk("done_pulses", dn, 1);
    chk("busy_whole_frame", busy_bad, 0);
    chk("byte_count", cnt, exp_len - first);
    if (cnt == exp_len - first) begin
      for (int f = first; f < exp_len; f++) begin
        i = base + f - first;
        if (cap_b[i] != exp_byte(f, n, exp_len, exp_ck)) begin
          if (bad_b == 0)
            $display("byte %0d: got %h want %h", f, cap_b[i],
                     exp_byte(f, n, exp_len, exp_ck));
          bad_b++;
        end
        if (f >= 2 && f < exp_len - 1 && cap_a[i] != (f - 2) / 2)
          bad_a++;
      end
      chk("checksum", int'(cap_b[cap_b.size() - 1]),
          int'(exp_ck));
    end
    chk("frame_bytes", bad_b, 0);
    chk("rd_addr_seq", bad_a, 0);
    chk("tx_byte_stable", stable_bad - s0, 0);
  endtask

  task automatic run_frame(input vec_t v);
    int base;
    int bad = 0;
    load_mem(v.pat);
    base = cap_b.size();
    @(posedge clk); #1;
    start = 1'b1;
    size  = v.size;
    @(posedge clk); #1;
    start = 1'b0;
    size  = 8'd0;
    chk("err_pulse", int'(err), int'(v.exp_err));
    chk("busy_on_start", int'(busy), v.exp_err ? 0 : 1);
    chk("tx_start_on_start", int'(tx_start), v.exp_err ? 0 : 1);
    if (v.exp_err) begin
      repeat (20) begin
        @(posedge clk); #1;
        if (err || busy || tx_start) bad++;
      end
      chk("err_quiet", bad, 0);
      chk("err_no_bytes", cap_b.size() - base, 0);
    end else begin
      chk("header_out", int'(tx_byte), 'hA5);
      wait_frame(base, 0, v.size, v.exp_len, v.exp_ck);
    end
  endtask

  initial begin
    int base;
    int e0;
    int ok;
    int nb;
    int bad;
    vecs[0] = '{8'd1,   0, 1'b0, 5,   8'h27};
    vecs[1] = '{8'd2,   1, 1'b0, 11,  8'h82};
    vecs[2] = '{8'd3,   2, 1'b0, 21,  8'h03};
    vecs[3] = '{8'd10,  2, 1'b0, 203, 8'h0A};
    vecs[4] = '{8'd0,   0, 1'b1, 0,   8'h00};
    vecs[5] = '{8'd11,  0, 1'b1, 0,   8'h00};
    vecs[6] = '{8'd255, 0, 1'b1, 0,   8'h00};

    rst      = 1'b1;
    start    = 1'b0;
    size     = 8'd0;
    model_en = 1'b1;
    td_man   = 1'b0;
    load_mem(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_tx_byte", int'(tx_byte), 0);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) run_frame(vecs[v]);

    // reset in the middle of an N=2 frame
    load_mem(1);
    e0 = n_edges;
    @(posedge clk); #1;
    start = 1'b1;
    size  = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    size  = 8'd0;
    ok = 0;
    for (int c = 0; c < 2000 && ok == 0; c++) begin
      @(posedge clk); #1;
      if (n_edges - e0 >= 3) ok = 1;
    end
    chk("third_edge_seen", ok, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_tx_start", int'(tx_start), 0);
    chk("abort_busy", int'(busy), 0);
    rst = 1'b0;
    nb  = cap_b.size();
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (tx_start || busy) bad++;
    end
    chk("quiet_after_abort", bad, 0);
    chk("no_bytes_after_abort", cap_b.size() - nb, 0);
    run_frame(vecs[0]);

    // done level high before header, plus a start mid-frame
    load_mem(0);
    model_en = 1'b0;
    td_man   = 1'b1;
    repeat (3) @(posedge clk);
    base = cap_b.size();
    #1;
    start = 1'b1;
    size  = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    size  = 8'd0;
    chk("held_hdr_start", int'(tx_start), 1);
    repeat (8) @(posedge clk);
    #1;
    chk("held_level_ignored", int'(tx_start), 1);
    start = 1'b1;
    size  = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    size  = 8'd0;
    chk("midframe_err", int'(err), 0);
    chk("midframe_busy", int'(busy), 1);
    chk("midframe_byte", int'(tx_byte), 'hA5);
    td_man = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    td_man = 1'b1;
    @(posedge clk); #1;
    chk("fresh_edge_completes", int'(tx_start), 0);
    td_man   = 1'b0;
    model_en = 1'b1;
    wait_frame(base, 1, 8'd1, 5, 8'h27);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
